// File: rtl/store_align_buffer.sv
// MEM-stage store buffer: narrows sb/sh/sw data to byte lanes, queues stores in a
// small FIFO, drains them to data memory over req/ack and flags loads to queued words.
module store_align_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_op,
  output logic             align_err,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [29:0]      r_word  [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic [3:0]       r_be    [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_align_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_hit;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = in_data;
    w_legal = 1'b0;
    case (in_op)
      2'b00: begin
        w_be    = 4'b1111;
        w_wdata = in_data;
        w_legal = (in_addr[1:0] == 2'b00);
      end
      2'b01: begin
        w_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_data[15:0]}};
        w_legal = ~in_addr[0];
      end
      2'b10: begin
        w_be    = 4'b0001 << in_addr[1:0];
        w_wdata = {4{in_data[7:0]}};
        w_legal = 1'b1;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = in_data;
        w_legal = 1'b0;
      end
    endcase
  end

  assign in_ready = (r_count != FULL_CNT);
  assign mem_req  = (r_count != '0);
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = mem_req & mem_ack;

  // Push and pop never target the same slot: a push into an empty FIFO has no pop,
  // and a full FIFO refuses pushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_accept & ~w_legal;
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_word[r_wptr]  <= in_addr[31:2];
      r_wdata[r_wptr] <= w_wdata;
      r_be[r_wptr]    <= w_be;
    end
  end

  // Head fields are forced to zero while empty so stale slots never show.
  assign mem_addr  = mem_req ? {r_word[r_rptr], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? r_wdata[r_rptr] : 32'h0;
  assign mem_be    = mem_req ? r_be[r_rptr] : 4'b0000;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && ((ld_addr >> 2) == {2'b00, r_word[i]})) w_hit = 1'b1;
    end
  end

  assign ld_hit    = w_hit;
  assign align_err = r_align_err;
  assign count     = r_count;

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: narrowing, alignment errors, full/empty
// behaviour, streaming with pointer wrap, load-hit detection and mid-run reset.
module tb_store_align_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        align_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [2:0]  count;

  int n_vec = 0;
  int n_bad = 0;

  store_align_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_op(in_op), .align_err(align_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    in_valid = v;
    in_op    = op;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    reset    = 1'b0;
    mem_ack  = 1'b0;
    ld_addr  = 32'h0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    reset = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // T1: SB to byte 3 of word 0x10
    drive(1'b1, 2'b10, 32'h13, 32'h0000_00A5);
    #1;
    chk("t1_no_bypass", 32'(mem_req), 32'd0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_be", 32'(mem_be), 32'b1000);
    chk("t1_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("t1_count", 32'(count), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t1_drained", 32'(count), 32'd0);

    // T2: SH upper half, then misaligned SW, reserved op, SH lower half
    drive(1'b1, 2'b01, 32'h22, 32'h1234_BEEF);
    step();
    drive(1'b1, 2'b00, 32'h06, 32'hDEAD_BEEF);
    chk("t2_sh_be", 32'(mem_be), 32'b1100);
    chk("t2_sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("t2_sh_addr", mem_addr, 32'h20);
    chk("t2_no_err_yet", 32'(align_err), 32'd0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t2_align_err", 32'(align_err), 32'd1);
    chk("t2_count_kept", 32'(count), 32'd1);
    step();
    chk("t2_err_pulse", 32'(align_err), 32'd0);
    drive(1'b1, 2'b11, 32'h0, 32'h1);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t2_rsvd_err", 32'(align_err), 32'd1);
    chk("t2_rsvd_count", 32'(count), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    drive(1'b1, 2'b01, 32'h34, 32'hAAAA_5678);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t2_shlo_be", 32'(mem_be), 32'b0011);
    chk("t2_shlo_wdata", mem_wdata, 32'h5678_5678);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t2_drained", 32'(count), 32'd0);

    // T3: fill to DEPTH, hold a fifth request, release with one ack
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 32'(4 * i), 32'h100 + 32'(i));
      step();
    end
    drive(1'b1, 2'b00, 32'h10, 32'h104);
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    step();
    chk("t3_held_count", 32'(count), 32'd4);
    chk("t3_head", mem_addr, 32'h0);
    chk("t3_head_data", mem_wdata, 32'h100);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t3_pop_count", 32'(count), 32'd3);
    chk("t3_ready_back", 32'(in_ready), 32'd1);
    chk("t3_next_head", mem_addr, 32'h4);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t3_refill", 32'(count), 32'd4);
    mem_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("t3_order", mem_addr, 32'(4 * i));
      chk("t3_order_data", mem_wdata, 32'h100 + 32'(i));
      step();
    end
    mem_ack = 1'b0;
    chk("t3_empty", 32'(count), 32'd0);

    // T4: stream of 10 with push and ack each cycle (first ack hits an empty FIFO)
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b00, 32'h200 + 32'(4 * i), 32'h5000 + 32'(i));
      if (i > 0) chk("t4_order", mem_addr, 32'h200 + 32'(4 * (i - 1)));
      step();
      chk("t4_count", 32'(count), 32'd1);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t4_last", mem_addr, 32'h224);
    chk("t4_last_data", mem_wdata, 32'h5009);
    step();
    mem_ack = 1'b0;
    chk("t4_empty", 32'(count), 32'd0);

    // T5: load-hit detection
    drive(1'b1, 2'b00, 32'h40, 32'h7777_7777);
    ld_addr = 32'h40;
    #1;
    chk("t5_no_same_cycle_hit", 32'(ld_hit), 32'd0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    ld_addr = 32'h43;
    #1;
    chk("t5_hit_43", 32'(ld_hit), 32'd1);
    ld_addr = 32'h44;
    #1;
    chk("t5_miss_44", 32'(ld_hit), 32'd0);
    ld_addr = 32'h40;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t5_after_pop", 32'(ld_hit), 32'd0);

    // T6: reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 32'h80 + 32'(4 * i), 32'(i));
      step();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("t6_queued", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_count_clr", 32'(count), 32'd0);
    chk("t6_addr_clr", mem_addr, 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_still_empty", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
